// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bundle: hazard inputs from ID/EX/MEM and per-register enables/flushes.
// Combinational request/response with no handshake, sampled every cycle.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_R1addr;
    logic [4:0]       ID_R2addr;
    logic             ID_R1used;
    logic             ID_R2used;
    logic [4:0]       EX_WReg1;
    logic             EX_MemRead;
    logic             EX_BranchTaken;
    logic             MEM_MemAccess;
    logic             clr_counters;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             memwb_flush;
    logic             mem_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_R1addr, ID_R2addr, ID_R1used, ID_R2used, EX_WReg1, EX_MemRead,
               EX_BranchTaken, MEM_MemAccess, clr_counters,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush,
               mem_busy, stall_cycles, flush_count
    );

    modport slave (
        input  ID_R1addr, ID_R2addr, ID_R1used, ID_R2used, EX_WReg1, EX_MemRead,
               EX_BranchTaken, MEM_MemAccess, clr_counters,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_flush,
               mem_busy, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipe control: MEM freeze, EX branch flush, ID/EX load-use stall, stall/flush counters.
// Controls are zero-latency combinational; freeze holds everything up to EX/MEM for MEM_LAT-1 cycles.
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    localparam bit         LONG_MEM  = (MEM_LAT >= 2);
    localparam logic [3:0] WAIT_INIT = LONG_MEM ? 4'(MEM_LAT - 2) : 4'd0;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wcnt;
    logic [3:0]       wcnt_nxt;
    logic             freeze;
    logic             load_use;
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign freeze = ((state == RUN) && bus.MEM_MemAccess && LONG_MEM) ||
                    ((state == WAIT) && (wcnt != 4'd0));

    assign load_use = bus.EX_MemRead && (bus.EX_WReg1 != 5'd0) &&
                      ((bus.ID_R1used && (bus.ID_R1addr == bus.EX_WReg1)) ||
                       (bus.ID_R2used && (bus.ID_R2addr == bus.EX_WReg1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // WAIT with wcnt==0 is the release cycle: MEM access is ignored so the frozen op can leave.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = WAIT_INIT;
                end
            end
            WAIT: begin
                if (wcnt != 4'd0) begin
                    wcnt_nxt = wcnt - 4'd1;
                end else begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    always_comb begin
        bus.pc_we       = 1'b1;
        bus.ifid_we     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_we     = 1'b1;
        bus.idex_flush  = 1'b0;
        bus.exmem_we    = 1'b1;
        bus.memwb_flush = 1'b0;
        bus.mem_busy    = 1'b0;
        if (!reset) begin
            bus.pc_we    = 1'b0;
            bus.ifid_we  = 1'b0;
            bus.idex_we  = 1'b0;
            bus.exmem_we = 1'b0;
        end else if (freeze) begin
            bus.pc_we       = 1'b0;
            bus.ifid_we     = 1'b0;
            bus.idex_we     = 1'b0;
            bus.exmem_we    = 1'b0;
            bus.memwb_flush = 1'b1;
            bus.mem_busy    = 1'b1;
        end else if (bus.EX_BranchTaken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else if (load_use) begin
            bus.pc_we      = 1'b0;
            bus.ifid_we    = 1'b0;
            bus.idex_flush = 1'b1;
        end
    end

    // A load-use squashed by a taken branch is not a stall.
    assign stall_inc = freeze || (load_use && !bus.EX_BranchTaken);
    assign flush_inc = !freeze && bus.EX_BranchTaken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (bus.clr_counters) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: four instances (MEM_LAT 1..4, 4-bit counters on the first)
// driven by shared stimulus and checked every cycle against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0] r1addr, r2addr, wreg;
    logic       r1used, r2used, memread, br, acc, clr;

    logic [7:0]  o_ctrl  [N];
    logic [15:0] o_stall [N];
    logic [15:0] o_flush [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : 16;
        pipe_hazard_ctrl_if #(.CNT_W(W)) bus ();
        assign bus.ID_R1addr      = r1addr;
        assign bus.ID_R2addr      = r2addr;
        assign bus.ID_R1used      = r1used;
        assign bus.ID_R2used      = r2used;
        assign bus.EX_WReg1       = wreg;
        assign bus.EX_MemRead     = memread;
        assign bus.EX_BranchTaken = br;
        assign bus.MEM_MemAccess  = acc;
        assign bus.clr_counters   = clr;
        assign o_ctrl[g]  = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we,
                             bus.idex_flush, bus.exmem_we, bus.memwb_flush, bus.mem_busy};
        assign o_stall[g] = 16'(bus.stall_cycles);
        assign o_flush[g] = 16'(bus.flush_count);
        pipe_hazard_ctrl #(.MEM_LAT(g + 1), .CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    end

    // Control vector bit order: pc_we ifid_we ifid_flush idex_we idex_flush exmem_we memwb_flush mem_busy
    localparam logic [7:0] C_RUN = 8'b1101_0100;
    localparam logic [7:0] C_FRZ = 8'b0000_0011;
    localparam logic [7:0] C_BR  = 8'b1111_1100;
    localparam logic [7:0] C_LU  = 8'b0001_1100;

    int busy    [N];   // frozen cycles still owed to the op in MEM
    bit rel     [N];   // next cycle is the release cycle
    int m_stall [N];
    int m_flush [N];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic int lat(int i);
        return i + 1;
    endfunction

    function automatic int sat_max(int i);
        return (i == 0) ? 15 : 65535;
    endfunction

    function automatic bit lu();
        return memread && (wreg != 5'd0) &&
               ((r1used && (r1addr == wreg)) || (r2used && (r2addr == wreg)));
    endfunction

    function automatic bit frozen(int i);
        return (busy[i] > 0) || (!rel[i] && acc && (lat(i) >= 2));
    endfunction

    function automatic logic [7:0] exp_ctrl(int i);
        if (!reset)    return 8'h00;
        if (frozen(i)) return C_FRZ;
        if (br)        return C_BR;
        if (lu())      return C_LU;
        return C_RUN;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ctrl lat%0d", lat(i)), 16'(o_ctrl[i]), 16'(exp_ctrl(i)));
            chk($sformatf("stall lat%0d", lat(i)), o_stall[i], reset ? 16'(m_stall[i]) : 16'd0);
            chk($sformatf("flush lat%0d", lat(i)), o_flush[i], reset ? 16'(m_flush[i]) : 16'd0);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            bit fr;
            bit l;
            fr = frozen(i);
            l  = lu();
            if (!reset) begin
                busy[i] = 0; rel[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else begin
                if (clr) begin
                    m_stall[i] = 0; m_flush[i] = 0;
                end else begin
                    if ((fr || (l && !br)) && m_stall[i] < sat_max(i)) m_stall[i]++;
                    if (!fr && br && m_flush[i] < sat_max(i)) m_flush[i]++;
                end
                if (busy[i] > 0) begin
                    busy[i]--;
                    rel[i] = (busy[i] == 0);
                end else if (rel[i]) begin
                    rel[i] = 0;
                end else if (acc && lat(i) >= 2) begin
                    busy[i] = lat(i) - 2;
                    rel[i]  = (busy[i] == 0);
                end
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle();
        r1addr = 5'd0; r2addr = 5'd0; wreg = 5'd0;
        r1used = 1'b0; r2used = 1'b0; memread = 1'b0; br = 1'b0; acc = 1'b0; clr = 1'b0;
    endtask

    task automatic clear();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic set_lu_r2();
        idle();
        memread = 1'b1; wreg = 5'd5; r2addr = 5'd5; r2used = 1'b1;
    endtask

    typedef struct {
        logic [4:0] r1, r2;
        logic       u1, u2;
        logic [4:0] w;
        logic       mr, b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, C_RUN};  // no match
        tbl[1] = '{5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, C_LU};   // R1 match
        tbl[2] = '{5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, C_LU};   // R2 match
        tbl[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, C_RUN};  // r0 never hazards
        tbl[4] = '{5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, C_RUN};  // unused source
        tbl[5] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, C_RUN};  // not a load
        tbl[6] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, C_BR};   // branch only
        tbl[7] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, C_BR};   // branch beats load-use

        idle();
        reset = 1'b0;
        #1;
        chk("reset ctrl immediate", 16'(o_ctrl[1]), 16'h0000);
        step();
        step();
        reset = 1'b1;

        for (int k = 0; k < 8; k++) begin
            idle();
            r1addr = tbl[k].r1; r2addr = tbl[k].r2; r1used = tbl[k].u1; r2used = tbl[k].u2;
            wreg = tbl[k].w; memread = tbl[k].mr; br = tbl[k].b;
            sample();
            chk($sformatf("table %0d", k), 16'(o_ctrl[1]), 16'(tbl[k].exp));
            advance();
        end

        // load-use stall then r0 destination
        clear();
        set_lu_r2();
        sample();
        chk("lu ctrl", 16'(o_ctrl[1]), 16'(C_LU));
        advance();
        r2addr = 5'd0; wreg = 5'd0;
        sample();
        chk("lu stall count", o_stall[1], 16'd1);
        chk("r0 no stall ctrl", 16'(o_ctrl[1]), 16'(C_RUN));
        advance();
        idle();
        sample();
        chk("r0 stall unchanged", o_stall[1], 16'd1);
        advance();

        // branch together with load-use
        clear();
        set_lu_r2();
        br = 1'b1;
        sample();
        chk("br+lu ctrl", 16'(o_ctrl[1]), 16'(C_BR));
        advance();
        idle();
        sample();
        chk("br+lu flush count", o_flush[1], 16'd1);
        chk("br+lu stall count", o_stall[1], 16'd0);
        advance();

        // MEM_LAT=3: two frozen cycles then a release cycle
        clear();
        acc = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk($sformatf("lat3 exmem/memwb c%0d", c), 16'(o_ctrl[2][2:1]),
                (c < 2) ? 16'h0001 : 16'h0002);
            advance();
        end
        acc = 1'b0;
        sample();
        chk("lat3 stall count", o_stall[2], 16'd2);
        advance();

        // branch during freeze (MEM_LAT=2)
        clear();
        acc = 1'b1; br = 1'b1;
        sample();
        chk("frozen no ifid_flush", 16'(o_ctrl[1][5]), 16'd0);
        chk("frozen mem_busy", 16'(o_ctrl[1][0]), 16'd1);
        advance();
        sample();
        chk("release ifid_flush", 16'(o_ctrl[1][5]), 16'd1);
        chk("release idex_flush", 16'(o_ctrl[1][3]), 16'd1);
        advance();
        idle();
        sample();
        chk("frozen br flush count", o_flush[1], 16'd1);
        advance();

        // 4-bit counter saturation and clear
        clear();
        set_lu_r2();
        for (int c = 0; c < 20; c++) step();
        idle();
        sample();
        chk("stall saturates", o_stall[0], 16'd15);
        advance();
        clr = 1'b1;
        step();
        clr = 1'b0;
        sample();
        chk("stall cleared", o_stall[0], 16'd0);
        advance();

        // reset mid-WAIT on MEM_LAT=4
        clear();
        acc = 1'b1;
        step();
        sample();
        chk("lat4 in wait busy", 16'(o_ctrl[3][0]), 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid-wait reset ctrl", 16'(o_ctrl[3]), 16'h0000);
        chk("mid-wait reset stall", o_stall[3], 16'd0);
        advance();
        acc = 1'b0;
        reset = 1'b1;
        sample();
        chk("after reset run ctrl", 16'(o_ctrl[3]), 16'(C_RUN));
        chk("after reset stall", o_stall[3], 16'd0);
        advance();

        // randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            r1addr  = 5'($urandom_range(0, 3));
            r2addr  = 5'($urandom_range(0, 3));
            wreg    = 5'($urandom_range(0, 3));
            r1used  = ($urandom_range(0, 99) < 70);
            r2used  = ($urandom_range(0, 99) < 70);
            memread = ($urandom_range(0, 99) < 50);
            br      = ($urandom_range(0, 99) < 15);
            acc     = ($urandom_range(0, 99) < 35);
            clr     = ($urandom_range(0, 99) < 2);
            reset   = ($urandom_range(0, 99) >= 1);
            step();
        end
        reset = 1'b1;
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
